// File: rtl/shared_reg_arbiter_pkg.sv
// Shared definitions for the round-robin register arbiter family:
// index-width helper and the informational activity state encoding.
package shared_reg_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    // Bits needed to index n items; at least 1 so a 2-entry index is legal.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: scans eff circularly from ptr
// and reports the first set bit as win, with any flagging that one was found.
module rr_pick
    import shared_reg_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = clog2(NREQ)
) (
    input  logic [NREQ-1:0] eff,
    input  logic [IDW-1:0]  ptr,
    output logic [IDW-1:0]  win,
    output logic            any
);

    always_comb begin
        int idx;
        // NOTE: every output gets a default before the search loop so no
        // path leaves it unassigned, which would otherwise infer a latch.
        win = '0;
        any = 1'b0;
        idx = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!any && eff[idx]) begin
                any = 1'b1;
                win = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin write arbiter sharing one W-bit register between NREQ clients;
// the winner's data is loaded and a one-cycle grant pulse is returned.
module shared_reg_arbiter
    import shared_reg_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = 8,
    localparam int IDW = clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ*W-1:0] wdata,
    input  logic            clr,
    output logic [NREQ-1:0] gnt,
    output logic [W-1:0]    q,
    output logic            q_vld,
    output logic [IDW-1:0]  owner
);

    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [W-1:0]    q_q, q_d;
    logic            q_vld_q, q_vld_d;
    logic [IDW-1:0]  owner_q, owner_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    arb_state_e      state_q, state_d;

    logic [NREQ-1:0] eff;
    logic [IDW-1:0]  win;
    logic            any;

    // Masking the live grant keeps a held request from winning twice in a row.
    assign eff = req & ~gnt_q;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .eff (eff),
        .ptr (ptr_q),
        .win (win),
        .any (any)
    );

    always_comb begin
        gnt_d   = '0;
        q_d     = q_q;
        q_vld_d = q_vld_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        if (clr) begin
            q_d     = '0;
            q_vld_d = 1'b0;
            owner_d = '0;
        end else if (any) begin
            // Indexed part-select reads only the winner's slice, so X on idle
            // clients' data never reaches q.
            q_d     = wdata[win*W +: W];
            gnt_d   = NREQ'(1) << win;
            owner_d = win;
            q_vld_d = 1'b1;
            ptr_d   = (win == IDW'(NREQ-1)) ? '0 : win + IDW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (|gnt_d)  state_d = ST_BUSY;
            ST_BUSY: if (!(|gnt_d)) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt_q   <= '0;
            q_q     <= '0;
            q_vld_q <= 1'b0;
            owner_q <= '0;
            ptr_q   <= '0;
            state_q <= ST_IDLE;
        end else begin
            gnt_q   <= gnt_d;
            q_q     <= q_d;
            q_vld_q <= q_vld_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            state_q <= state_d;
        end
    end

    assign gnt   = gnt_q;
    assign q     = q_q;
    assign q_vld = q_vld_q;
    assign owner = owner_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter (NREQ=4, W=8) with hand-computed
// expectations checked by immediate assertions.
module tb_shared_reg_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic        clr;
    logic [3:0]  gnt;
    logic [7:0]  q;
    logic        q_vld;
    logic [1:0]  owner;

    int tests_run = 0;
    int tests_failed = 0;

    shared_reg_arbiter #(.NREQ(4), .W(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .wdata (wdata),
        .clr   (clr),
        .gnt   (gnt),
        .q     (q),
        .q_vld (q_vld),
        .owner (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [3:0] e_gnt, input logic [7:0] e_q,
                             input logic e_vld, input logic [1:0] e_owner);
        check({tag, ".gnt"},   32'(gnt),   32'(e_gnt));
        check({tag, ".q"},     32'(q),     32'(e_q));
        check({tag, ".q_vld"}, 32'(q_vld), 32'(e_vld));
        check({tag, ".owner"}, 32'(owner), 32'(e_owner));
    endtask

    initial begin
        rst   = 1'b0;
        req   = '0;
        clr   = 1'b0;
        wdata = '0;
        #1;
        check_all("por", 4'b0000, 8'h00, 1'b0, 2'd0);
        step();
        step();
        rst = 1'b1;

        // Single requester; other slices X to show they cannot leak into q.
        wdata = 'x;
        wdata[23:16] = 8'hA5;
        req = 4'b0100;
        step();
        check_all("single1", 4'b0100, 8'hA5, 1'b1, 2'd2);
        step();
        check("single_masked.gnt", 32'(gnt), 32'h0);
        check("single_masked.q", 32'(q), 32'hA5);
        step();
        check("single_again.gnt", 32'(gnt), 32'h4);

        // Full contention; pointer is now 3, so requester 3 wins first.
        wdata = 32'h13121110;
        req = 4'b1111;
        step();
        check_all("pre_reset", 4'b1000, 8'h13, 1'b1, 2'd3);

        // Asynchronous reset mid-cycle, checked before any clock edge.
        #2;
        rst = 1'b0;
        #1;
        check_all("async_reset", 4'b0000, 8'h00, 1'b0, 2'd0);
        step();
        rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("rr%0d.gnt", i), 32'(gnt), 32'(4'b0001 << (i % 4)));
            check($sformatf("rr%0d.q", i), 32'(q), 32'h10 + 32'(i % 4));
        end

        // Pointer wrap after the grant to requester 3.
        req = 4'b1001;
        step();
        check_all("wrap0", 4'b0001, 8'h10, 1'b1, 2'd0);
        step();
        check_all("wrap3", 4'b1000, 8'h13, 1'b1, 2'd3);
        req = 4'b0000;
        step();
        check("wrap_idle.gnt", 32'(gnt), 32'h0);

        // clr beats a pending request, which is then granted next cycle.
        wdata = 32'h00007700;
        req = 4'b0010;
        clr = 1'b1;
        step();
        check_all("clr", 4'b0000, 8'h00, 1'b0, 2'd0);
        clr = 1'b0;
        step();
        check_all("after_clr", 4'b0010, 8'h77, 1'b1, 2'd1);
        req = 4'b0000;
        step();
        check("after_clr_idle.gnt", 32'(gnt), 32'h0);

        // Idle hold after a write of 3C.
        wdata = 32'h003C0000;
        req = 4'b0100;
        step();
        check_all("hold_write", 4'b0100, 8'h3C, 1'b1, 2'd2);
        req = 4'b0000;
        wdata = 32'hFFFFFFFF;
        for (int i = 0; i < 5; i++) begin
            step();
            check_all($sformatf("hold%0d", i), 4'b0000, 8'h3C, 1'b1, 2'd2);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/shared_reg_arbiter.md
Name: shared_reg_arbiter

Overview:
- Round-robin write arbiter that shares one W-bit storage register between NREQ requesters.
- Each cycle it picks at most one requesting client and loads that client's data into the register.
- It returns a one-cycle grant pulse to the winning client and publishes the owner ID alongside the register value.
- Sits between independent producer blocks and any consumer that reads a single shared configuration or status word.

Parameters:
- NREQ, 4, number of requesters; legal range 2..16.
- W, 8, width of the shared register and of each requester's data.
- IDW, derived as clog2(NREQ); localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- req  input  NREQ  per-requester write request; bit i belongs to requester i.
- wdata  input  NREQ*W  packed write data; requester i drives bits [i*W +: W].
- clr  input  1  synchronous clear of the shared register.
- gnt  output  NREQ  registered one-hot grant pulse, high for one cycle.
- q  output  W  shared register contents.
- q_vld  output  1  high once q has been written since the last reset or clr.
- owner  output  IDW  index of the requester that last wrote q.

Behaviour:
- Reset (rst=0, asynchronous): q=0, gnt=0, owner=0, q_vld=0, internal pointer ptr=0.
  - Reset takes effect immediately, mid-transfer included; any grant in flight is lost.
  - The first arbitration after release starts from ptr=0.
- Effective request: eff[i] = req[i] & ~gnt[i].
  - A requester whose gnt bit is high this cycle is masked, so the same request is never granted twice.
- Winner selection: combinational search of eff in circular order ptr, ptr+1, ..., NREQ-1, 0, ..., ptr-1; the first set bit wins.
- On a rising edge with clr=0 and eff nonzero:
  - q <= wdata slice of the winner;
  - gnt <= one-hot(winner);
  - owner <= winner;
  - q_vld <= 1;
  - ptr <= (winner+1) mod NREQ, wrapping NREQ-1 back to 0.
- On a rising edge with clr=0 and eff=0: gnt <= 0; q, owner, q_vld and ptr hold.
- On a rising edge with clr=1: q <= 0, q_vld <= 0, owner <= 0, gnt <= 0, ptr holds.
  - clr beats any request; no grant is issued that cycle and the requests stay pending.
- Latency: data is visible on q, and gnt is seen, one clock edge after the request is sampled.
- Requester protocol:
  - Hold req and wdata stable until gnt[i] is seen high.
  - Drop req in the gnt cycle, or keep it high to queue another write; the mask guarantees at least one cycle of gap.
- Fairness: with all requesters continuously active, grants rotate strictly 0,1,...,NREQ-1,0,...; no requester waits more than NREQ-1 grants.
- State: two-state FSM, IDLE and BUSY.
  - IDLE -> BUSY on any grant.
  - BUSY -> IDLE when a cycle produces no grant.
  - The state is informational only (drives no output); implementation may reduce it to |gnt.
- wdata of non-winning requesters is ignored; X on those slices must not propagate to q.

Decomposition:
- Shared header arb_defs.vh:
  - clog2 function used to derive IDW;
  - localparams ST_IDLE=1'b0 and ST_BUSY=1'b1.
- One natural sub-module, rr_pick: purely combinational masked round-robin priority encoder.
  - Inputs eff[NREQ] and ptr[IDW]; outputs win[IDW] and any.
  - Reused by later arbiters.
- The top level holds all flops: q, gnt, owner, q_vld, ptr, state.

Test Plan:
- Reset values: assert rst=0 mid-simulation with req=4'b1111 -> q=0, gnt=0, owner=0, q_vld=0 immediately, without waiting for a clock edge; after release, the first grant goes to requester 0.
- Single requester: req=4'b0100, wdata[2]=8'hA5 -> next edge q=8'hA5, gnt=4'b0100, owner=2, q_vld=1; req held high -> following cycle gnt=0 (masked), third cycle gnt=4'b0100 again.
- Full contention: req=4'b1111, wdata[i]=8'h10+i, held 8 cycles -> gnt sequence 0001,0010,0100,1000,0001,... and q sequence 10,11,12,13,10,...
- Pointer wrap: after a grant to requester 3, apply req=4'b1001 -> requester 0 wins, then requester 3.
- clr collision: clr=1 with req=4'b0010 -> q=0, q_vld=0, gnt=0; next cycle with clr=0 -> gnt=4'b0010, q=wdata[1].
- Idle hold: req=0 for 5 cycles after a write of 8'h3C -> q stays 8'h3C, q_vld stays 1, gnt stays 0.
